// File: rtl/video_pattern_gen.sv
// Video timing generator with run-time selectable test patterns and frame counting.
// Outputs are registered one clock after the hc/vc counters.
module video_pattern_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   DATA_W   = 8,
  parameter int   CHANNELS = 1,
  parameter int   CK_LOG2  = 3,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(H_TOTAL),
  localparam int  VW       = $clog2(V_TOTAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  output logic                         hs,
  output logic                         vs,
  output logic                         de,
  output logic [HW-1:0]                x,
  output logic [VW-1:0]                y,
  output logic [CHANNELS*DATA_W-1:0]   data,
  output logic                         frame_start,
  output logic [15:0]                  frame_cnt,
  output logic                         state_dbg
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          CH_STEP   = (DATA_W >= 2) ? (1 << (DATA_W - 2)) : 0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state;
  logic [HW-1:0]                hc;
  logic [VW-1:0]                vc;
  logic [2:0]                   mode_r;
  logic [15:0]                  lfsr;

  logic [31:0]                  hcw;
  logic [31:0]                  vcw;
  logic                         at_origin;
  logic                         last_h;
  logic                         last_v;
  logic                         active;
  logic                         hs_n;
  logic                         vs_n;
  logic [2:0]                   mode_eff;
  logic [15:0]                  lfsr_cur;
  logic [15:0]                  lfsr_nxt;
  logic [DATA_W-1:0]            p;
  logic [CHANNELS*DATA_W-1:0]   pix;

  assign state_dbg = (state == RUN);

  always_comb begin
    hcw       = 32'(hc);
    vcw       = 32'(vc);
    at_origin = (hc == '0) && (vc == '0);
    last_h    = (hcw == 32'(H_TOTAL - 1));
    last_v    = (vcw == 32'(V_TOTAL - 1));
    active    = (hcw < 32'(H_ACTIVE)) && (vcw < 32'(V_ACTIVE));
    hs_n      = ((hcw >= 32'(H_ACTIVE + H_FP)) && (hcw < 32'(H_ACTIVE + H_FP + H_SYNC)))
                ? HS_POL : ~HS_POL;
    vs_n      = ((vcw >= 32'(V_ACTIVE + V_FP)) && (vcw < 32'(V_ACTIVE + V_FP + V_SYNC)))
                ? VS_POL : ~VS_POL;
    // The pixel at (0,0) already belongs to the new frame, so it sees the live mode
    // input and a freshly seeded LFSR rather than the registered copies.
    mode_eff  = at_origin ? mode : mode_r;
    lfsr_cur  = at_origin ? LFSR_SEED : lfsr;
    lfsr_nxt  = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? LFSR_TAPS : 16'h0000);

    p = '0;
    case (mode_eff)
      3'd0: p = DATA_W'(hcw);
      3'd1: p = DATA_W'(vcw);
      3'd2: p = (hcw[CK_LOG2] ^ vcw[CK_LOG2]) ? {DATA_W{1'b1}} : '0;
      3'd3: p = DATA_W'(hcw + vcw);
      3'd4: p = DATA_W'(hcw + {16'h0000, frame_cnt});
      3'd5: p = lfsr_cur[DATA_W-1:0];
      3'd6: p[DATA_W-1] = 1'b1;
      default: p = '0;
    endcase

    pix = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pix[c*DATA_W +: DATA_W] = p + DATA_W'(c * CH_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hc          <= '0;
      vc          <= '0;
      mode_r      <= '0;
      lfsr        <= LFSR_SEED;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      data        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          hc          <= '0;
          vc          <= '0;
          hs          <= ~HS_POL;
          vs          <= ~VS_POL;
          de          <= 1'b0;
          x           <= '0;
          y           <= '0;
          data        <= '0;
          frame_start <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          x           <= hc;
          y           <= vc;
          hs          <= hs_n;
          vs          <= vs_n;
          de          <= active;
          data        <= active ? pix : '0;
          frame_start <= at_origin;
          mode_r      <= mode_eff;
          if (active) lfsr <= lfsr_nxt;
          // en is only consulted on the last clock of a frame, so frames never truncate.
          if (last_h) begin
            hc <= '0;
            if (last_v) begin
              vc        <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              if (!en) state <= IDLE;
            end else begin
              vc <= vc + 1'b1;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 14x7 raster, two 8-bit channels, 2-pixel checker squares.
module tb_video_pattern_gen;

  localparam int FRAME = 98;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic        hs;
  logic        vs;
  logic        de;
  logic [3:0]  x;
  logic [2:0]  y;
  logic [15:0] data;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        state_dbg;

  logic [42:0] obs;
  logic [42:0] want;
  logic [42:0] exp_q[$];
  int          chk_cnt;
  int          pass_cnt;

  assign obs = {frame_start, hs, vs, de, x, y, data, frame_cnt};

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DATA_W(8), .CHANNELS(2), .CK_LOG2(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .data(data),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector of one whole frame, from frame_start to the last blank pixel.
  task automatic push_frame(input int md, input int f);
    logic [15:0] l;
    logic [7:0]  p;
    logic [15:0] d;
    logic [15:0] fc;
    int          hc;
    int          vc;
    logic        act;
    l = 16'hACE1;
    for (int k = 0; k < FRAME; k++) begin
      hc  = k % 14;
      vc  = k / 14;
      act = (hc < 8) && (vc < 4);
      case (md)
        0: p = 8'(hc);
        1: p = 8'(vc);
        2: p = ((((hc >> 1) ^ (vc >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
        3: p = 8'(hc + vc);
        4: p = 8'(hc + f);
        5: p = l[7:0];
        6: p = 8'h80;
        default: p = 8'h00;
      endcase
      if (md == 5 && act) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      d  = act ? {p + 8'd64, p} : 16'h0000;
      fc = (k == FRAME - 1) ? 16'(f + 1) : 16'(f);
      exp_q.push_back({(k == 0), (hc >= 10 && hc < 12), (vc == 5), act,
                       4'(hc), 3'(vc), d, fc});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs !== 43'h0) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, 43'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_timing();
    int lat;
    int n_de;
    int n_hs;
    int n_vs;
    en = 1'b1; mode = 3'd0;
    lat = 0;
    while (frame_start !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat != 2) $display("FAIL start_latency got=%0d exp=2", lat);
    else pass_cnt++;
    push_frame(0, 0);
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      want = exp_q.pop_front();
      chk_cnt++;
      if (obs !== want) $display("FAIL timing_frame k=%0d got=%h exp=%h", k, obs, want);
      else pass_cnt++;
      if (de === 1'b1) n_de++;
      if (hs === 1'b1) n_hs++;
      if (vs === 1'b1) n_vs++;
    end
    chk_cnt++;
    if (n_de != 32) $display("FAIL de_count got=%0d exp=32", n_de); else pass_cnt++;
    chk_cnt++;
    if (n_hs != 14) $display("FAIL hs_count got=%0d exp=14", n_hs); else pass_cnt++;
    chk_cnt++;
    if (n_vs != 14) $display("FAIL vs_count got=%0d exp=14", n_vs); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (frame_start !== 1'b1 || frame_cnt !== 16'd1)
      $display("FAIL frame_period got fs=%b cnt=%0d exp fs=1 cnt=1", frame_start, frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_mode_latch();
    logic [7:0] ck_tab [8];
    ck_tab = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    push_frame(0, 1);
    push_frame(2, 2);
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      want = exp_q.pop_front();
      chk_cnt++;
      if (obs !== want) $display("FAIL mode_hold k=%0d got=%h exp=%h", k, obs, want);
      else pass_cnt++;
      if (k == 40) mode = 3'd2;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      chk_cnt++;
      if (obs !== want) $display("FAIL checker_frame k=%0d got=%h exp=%h", k, obs, want);
      else pass_cnt++;
      chk_cnt++;
      if (data !== {ck_tab[k] + 8'd64, ck_tab[k]})
        $display("FAIL checker_line0 px=%0d got=%h exp=%h", k, data, {ck_tab[k] + 8'd64, ck_tab[k]});
      else pass_cnt++;
    end
  endtask

  task automatic test_stop();
    int lat;
    for (int k = 8; k < FRAME; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      chk_cnt++;
      if (obs !== want) $display("FAIL stop_frame k=%0d got=%h exp=%h", k, obs, want);
      else pass_cnt++;
      if (k == 28) en = 1'b0;
    end
    chk_cnt++;
    if (frame_cnt !== 16'd3) $display("FAIL stop_count got=%0d exp=3", frame_cnt);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs !== {27'h0, 16'd3}) $display("FAIL stop_idle cyc=%0d got=%h exp=%h", i, obs, {27'h0, 16'd3});
      else pass_cnt++;
    end
    en = 1'b1;
    lat = 0;
    while (frame_start !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat != 2 || x !== 4'd0 || y !== 3'd0 || frame_cnt !== 16'd3)
      $display("FAIL restart got lat=%0d x=%0d y=%0d cnt=%0d exp lat=2 x=0 y=0 cnt=3", lat, x, y, frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_lfsr();
    logic [7:0] seq_a [32];
    int         n;
    int         idx;
    mode = 3'd5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    chk_cnt++;
    if (n != FRAME) $display("FAIL lfsr_wait_frame got=%0d exp=%0d", n, FRAME);
    else pass_cnt++;
    push_frame(5, 4);
    push_frame(5, 5);
    for (int fr = 0; fr < 2; fr++) begin
      idx = 0;
      for (int k = 0; k < FRAME; k++) begin
        if (fr > 0 || k > 0) @(negedge clk);
        want = exp_q.pop_front();
        chk_cnt++;
        if (obs !== want) $display("FAIL lfsr_frame f=%0d k=%0d got=%h exp=%h", fr, k, obs, want);
        else pass_cnt++;
        if (k == 0) begin
          chk_cnt++;
          if (data[7:0] !== 8'hE1) $display("FAIL lfsr_first f=%0d got=%h exp=e1", fr, data[7:0]);
          else pass_cnt++;
        end
        if (de === 1'b1 && idx < 32) begin
          if (fr == 0) seq_a[idx] = data[7:0];
          else begin
            chk_cnt++;
            if (data[7:0] !== seq_a[idx])
              $display("FAIL lfsr_repeat px=%0d got=%h exp=%h", idx, data[7:0], seq_a[idx]);
            else pass_cnt++;
          end
          idx++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    chk_cnt++;
    if (frame_start !== 1'b1) $display("FAIL rmid_frame_start got=%b exp=1", frame_start);
    else pass_cnt++;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if (obs !== 43'h0) $display("FAIL reset_mid got=%h exp=%h", obs, 43'h0);
    else pass_cnt++;
    lat = 0;
    while (frame_start !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat != 2 || frame_cnt !== 16'd0)
      $display("FAIL rmid_restart got lat=%0d cnt=%0d exp lat=2 cnt=0", lat, frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_patterns();
    int md_tab [5];
    int n;
    md_tab = '{1, 3, 4, 6, 7};
    for (int i = 0; i < 5; i++) begin
      mode = 3'(md_tab[i]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (frame_start !== 1'b1 && n < 200);
      chk_cnt++;
      if (n >= 200) $display("FAIL pattern_wait md=%0d got=timeout exp=frame_start", md_tab[i]);
      else pass_cnt++;
      push_frame(md_tab[i], i + 1);
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        want = exp_q.pop_front();
        chk_cnt++;
        if (obs !== want) $display("FAIL pattern md=%0d k=%0d got=%h exp=%h", md_tab[i], k, obs, want);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rst = 1'b1;
    en = 1'b0;
    mode = 3'd0;
    test_reset();
    test_timing();
    test_mode_latch();
    test_stop();
    test_lfsr();
    test_reset_mid();
    test_patterns();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
